// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the hazard-tracking entry, forward-select encoding and
// the hard-wired zero register.
package cpu_pkg;

  // Widest register address the tracking entry can carry; narrower cores zero-extend.
  localparam int REG_AW_MAX = 16;

  localparam logic [REG_AW_MAX-1:0] REG0 = '0;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic                  is_load;
    logic [REG_AW_MAX-1:0] dst;
  } trk_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Finds the youngest in-flight writer of one source operand and reports its
// forward select and whether that writer is a load.
module hazard_match
  import cpu_pkg::*;
#(
  parameter int NUM_TRK = 3,
  parameter int FWD_W   = $clog2(NUM_TRK + 1)
) (
  input  logic [REG_AW_MAX-1:0] src_i,
  input  logic                  src_used_i,
  input  trk_entry_t            trk_i [NUM_TRK],
  output logic                  hit_o,
  output logic [FWD_W-1:0]      fwd_sel_o,
  output logic                  is_load_hit_o
);

  // Scan oldest to youngest so the lowest matching index is the one that sticks.
  always_comb begin
    hit_o         = 1'b0;
    fwd_sel_o     = FWD_W'(FWD_RF);
    is_load_hit_o = 1'b0;
    for (int k = NUM_TRK - 1; k >= 0; k--) begin
      if (trk_i[k].valid && trk_i[k].wen && (trk_i[k].dst == src_i) &&
          (src_i != REG0) && src_used_i) begin
        hit_o         = 1'b1;
        fwd_sel_o     = FWD_W'(k + 1);
        is_load_hit_o = trk_i[k].is_load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard control beside ID: tracks in-flight destinations, drives forwarding
// selects, load-use stall/bubble and redirect flush, plus saturating event counters.
module pipe_hazard_unit
  import cpu_pkg::*;
#(
  parameter int NUM_TRK  = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_RDY = 2,
  parameter int BR_STAGE = 1,
  parameter int CNT_W    = 32,
  localparam int FWD_W   = $clog2(NUM_TRK + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic              id_wen_i,
  input  logic              id_is_load_i,
  input  logic              redirect_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic [FWD_W-1:0]  fwd_rs_o,
  output logic [FWD_W-1:0]  fwd_rt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [FWD_W-1:0] LOAD_SEL_MAX = FWD_W'(LOAD_RDY);

  trk_entry_t trk_q [NUM_TRK];
  trk_entry_t trk_d [NUM_TRK];

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic rs_hit, rt_hit, rs_load, rt_load;
  logic stall;

  hazard_match #(.NUM_TRK(NUM_TRK), .FWD_W(FWD_W)) u_match_rs (
    .src_i         (REG_AW_MAX'(id_rs_i)),
    .src_used_i    (id_rs_used_i),
    .trk_i         (trk_q),
    .hit_o         (rs_hit),
    .fwd_sel_o     (fwd_rs_o),
    .is_load_hit_o (rs_load)
  );

  hazard_match #(.NUM_TRK(NUM_TRK), .FWD_W(FWD_W)) u_match_rt (
    .src_i         (REG_AW_MAX'(id_rt_i)),
    .src_used_i    (id_rt_used_i),
    .trk_i         (trk_q),
    .hit_o         (rt_hit),
    .fwd_sel_o     (fwd_rt_o),
    .is_load_hit_o (rt_load)
  );

  // A redirect suppresses the stall: the stalled instruction is being thrown away.
  always_comb begin
    stall = id_valid_i && !redirect_i &&
            ((rs_hit && rs_load && (fwd_rs_o <= LOAD_SEL_MAX)) ||
             (rt_hit && rt_load && (fwd_rt_o <= LOAD_SEL_MAX)));
  end

  assign stall_o     = stall;
  assign bubble_o    = stall;
  assign flush_o     = redirect_i;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  always_comb begin
    if (stall || redirect_i) begin
      trk_d[0] = '0;
    end else begin
      trk_d[0].valid   = id_valid_i;
      trk_d[0].wen     = id_wen_i;
      trk_d[0].is_load = id_is_load_i;
      trk_d[0].dst     = REG_AW_MAX'(id_dst_i);
    end
    for (int k = 1; k < NUM_TRK; k++) begin
      trk_d[k] = trk_q[k-1];
      if (redirect_i && (k <= BR_STAGE)) begin
        trk_d[k].valid = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect_i && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TRK; k++) begin
        trk_q[k] <= '0;
      end
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_TRK; k++) begin
        trk_q[k] <= trk_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: expected outputs are queued per step and
// popped when the combinational outputs settle.
module tb_pipe_hazard_unit;

  logic       clk_i = 1'b0;
  logic       rst_n;
  logic       id_valid_i;
  logic [4:0] id_rs_i, id_rt_i, id_dst_i;
  logic       id_rs_used_i, id_rt_used_i, id_wen_i, id_is_load_i;
  logic       redirect_i;
  logic       stall_o, bubble_o, flush_o;
  logic [1:0] fwd_rs_o, fwd_rt_o;
  logic [3:0] stall_cnt_o, flush_cnt_o;

  typedef struct {
    string      tag;
    logic       stall;
    logic       flush;
    logic [1:0] frs;
    logic [1:0] frt;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_unit #(.CNT_W(4)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_rs_used_i (id_rs_used_i),
    .id_rt_used_i (id_rt_used_i),
    .id_dst_i     (id_dst_i),
    .id_wen_i     (id_wen_i),
    .id_is_load_i (id_is_load_i),
    .redirect_i   (redirect_i),
    .stall_o      (stall_o),
    .bubble_o     (bubble_o),
    .flush_o      (flush_o),
    .fwd_rs_o     (fwd_rs_o),
    .fwd_rt_o     (fwd_rt_o),
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one ID-stage instruction plus the redirect line.
  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic rsu,
                               input logic [4:0] rt, input logic rtu, input logic [4:0] dst,
                               input logic wen, input logic ld, input logic redir);
    id_valid_i   = v;
    id_rs_i      = rs;
    id_rs_used_i = rsu;
    id_rt_i      = rt;
    id_rt_used_i = rtu;
    id_dst_i     = dst;
    id_wen_i     = wen;
    id_is_load_i = ld;
    redirect_i   = redir;
  endtask

  task automatic pushExp(input string tag, input logic st, input logic fl,
                         input logic [1:0] frs, input logic [1:0] frt,
                         input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    e.tag = tag; e.stall = st; e.flush = fl; e.frs = frs; e.frt = frt; e.sc = sc; e.fc = fc;
    expQ.push_back(e);
  endtask

  task automatic cmp(input string tag, input string what, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (expQ.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      cmp(e.tag, "stall", {3'b0, stall_o}, {3'b0, e.stall});
      cmp(e.tag, "bubble", {3'b0, bubble_o}, {3'b0, e.stall});
      cmp(e.tag, "flush", {3'b0, flush_o}, {3'b0, e.flush});
      cmp(e.tag, "fwd_rs", {2'b0, fwd_rs_o}, {2'b0, e.frs});
      cmp(e.tag, "fwd_rt", {2'b0, fwd_rt_o}, {2'b0, e.frt});
      cmp(e.tag, "stall_cnt", stall_cnt_o, e.sc);
      cmp(e.tag, "flush_cnt", flush_cnt_o, e.fc);
    end
  endtask

  function automatic logic [3:0] sat(input int v);
    return (v > 15) ? 4'hF : 4'(v);
  endfunction

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    pushExp("reset", 0, 0, 0, 0, 0, 0); checkOutput();
    @(negedge clk_i); rst_n = 1'b1;

    // ALU forwarding: add $3, then two consumers of $3
    applyStimulus(1, 1, 1, 2, 1, 3, 1, 0, 0);
    pushExp("add3", 0, 0, 0, 0, 0, 0); #1 checkOutput();
    @(negedge clk_i); applyStimulus(1, 3, 1, 0, 1, 6, 1, 0, 0);
    pushExp("use3_e0", 0, 0, 1, 0, 0, 0); #1 checkOutput();
    @(negedge clk_i); applyStimulus(1, 3, 1, 3, 1, 7, 1, 0, 0);
    pushExp("use3_e1", 0, 0, 2, 2, 0, 0); #1 checkOutput();

    // Load-use: lw $4 then a consumer of $4 on rt
    @(negedge clk_i); applyStimulus(1, 0, 0, 0, 0, 4, 1, 1, 0);
    pushExp("lw4", 0, 0, 0, 0, 0, 0); #1 checkOutput();
    @(negedge clk_i); applyStimulus(1, 1, 1, 4, 1, 8, 1, 0, 0);
    pushExp("lu_stall1", 1, 0, 0, 1, 0, 0); #1 checkOutput();
    @(negedge clk_i);
    pushExp("lu_stall2", 1, 0, 0, 2, 1, 0); #1 checkOutput();
    @(negedge clk_i);
    pushExp("lu_release", 0, 0, 0, 3, 2, 0); #1 checkOutput();

    // Youngest writer wins; $0 never forwards
    @(negedge clk_i); applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0);
    pushExp("w5_old", 0, 0, 0, 0, 2, 0); #1 checkOutput();
    @(negedge clk_i); applyStimulus(1, 0, 0, 0, 0, 9, 1, 0, 0);
    pushExp("w9", 0, 0, 0, 0, 2, 0); #1 checkOutput();
    @(negedge clk_i); applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0);
    pushExp("w5_new", 0, 0, 0, 0, 2, 0); #1 checkOutput();
    @(negedge clk_i); applyStimulus(1, 5, 1, 0, 1, 0, 1, 0, 0);
    pushExp("youngest", 0, 0, 1, 0, 2, 0); #1 checkOutput();
    @(negedge clk_i); applyStimulus(1, 0, 1, 0, 1, 10, 1, 0, 0);
    pushExp("reg0", 0, 0, 0, 0, 2, 0); #1 checkOutput();

    // Redirect flushes entries 0 and 1 on the next edge
    @(negedge clk_i); applyStimulus(1, 10, 1, 0, 0, 11, 1, 0, 1);
    pushExp("redirect", 0, 1, 1, 0, 2, 0); #1 checkOutput();
    @(negedge clk_i); applyStimulus(1, 10, 1, 11, 1, 0, 0, 0, 0);
    pushExp("post_flush", 0, 0, 0, 0, 2, 1); #1 checkOutput();

    // Load-use coinciding with redirect: flush only
    @(negedge clk_i); applyStimulus(1, 0, 0, 0, 0, 12, 1, 1, 0);
    pushExp("lw12", 0, 0, 0, 0, 2, 1); #1 checkOutput();
    @(negedge clk_i); applyStimulus(1, 12, 1, 0, 0, 13, 1, 0, 1);
    pushExp("lu_redirect", 0, 1, 1, 0, 2, 1); #1 checkOutput();
    @(negedge clk_i); applyStimulus(1, 12, 1, 0, 0, 13, 1, 0, 0);
    pushExp("lu_redirect_after", 0, 0, 0, 0, 2, 2); #1 checkOutput();

    // Reset asserted in the middle of a load-use stall
    @(negedge clk_i); applyStimulus(1, 0, 0, 0, 0, 14, 1, 1, 0);
    pushExp("lw14", 0, 0, 0, 0, 2, 2); #1 checkOutput();
    @(negedge clk_i); applyStimulus(1, 14, 1, 0, 0, 15, 1, 0, 0);
    pushExp("stall14_1", 1, 0, 1, 0, 2, 2); #1 checkOutput();
    @(negedge clk_i);
    pushExp("stall14_2", 1, 0, 2, 0, 3, 2); #1 checkOutput();
    #2 rst_n = 1'b0;
    pushExp("mid_reset", 0, 0, 0, 0, 0, 0); #1 checkOutput();
    @(negedge clk_i); rst_n = 1'b1;
    pushExp("after_reset", 0, 0, 0, 0, 0, 0); #1 checkOutput();

    // Saturation: ten load/use pairs give 20 stall cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i); applyStimulus(1, 0, 0, 0, 0, 16, 1, 1, 0);
      pushExp("sat_lw", 0, 0, 0, 0, sat(2 * i), 0); #1 checkOutput();
      @(negedge clk_i); applyStimulus(1, 16, 1, 0, 0, 17, 1, 0, 0);
      pushExp("sat_s1", 1, 0, 1, 0, sat(2 * i), 0); #1 checkOutput();
      @(negedge clk_i);
      pushExp("sat_s2", 1, 0, 2, 0, sat(2 * i + 1), 0); #1 checkOutput();
      @(negedge clk_i);
      pushExp("sat_rel", 0, 0, 3, 0, sat(2 * i + 2), 0); #1 checkOutput();
    end
    @(negedge clk_i); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    pushExp("sat_final", 0, 0, 0, 0, 4'hF, 0); #1 checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
